lstm_ctxt_sched: RTL and testbench

Parametrised per-process context scheduler between the event input buffer and the LSTM core. Accepts syscall/branch events tagged with a PID, keeps one PID resident in the core, and performs full context switches through an on-chip Process Context Table (PCT) holding cell state, hidden state and branch bookkeeping. Unseen PIDs start from a zero context, and branches beyond a configurable limit are dropped.

---
 rtl/lstm_ctxt_pkg.sv | 23 ++
 rtl/lstm_ctxt_sched_pct_ram.sv | 25 ++
 rtl/lstm_ctxt_sched.sv | 125 ++++++++++++
 tb/tb_lstm_ctxt_sched.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lstm_ctxt_pkg.sv
// lstm_ctxt_pkg: shared types for the LSTM context scheduler
//   state_t      scheduler FSM states
//   TYPE_SYS/BR  event type encodings
//   pct_entry_w  width of a PCT entry {br_cnt, br_done, ct, ht}
package lstm_ctxt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_LOAD_RD,
        S_LOAD_APPLY,
        S_ISSUE,
        S_DROP
    } state_t;

    localparam logic TYPE_SYS = 1'b0;
    localparam logic TYPE_BR  = 1'b1;

    function automatic int pct_entry_w(input int cnt_w, input int ctxt_w);
        return cnt_w + 1 + 2 * ctxt_w;
    endfunction

endpackage

// File: rtl/lstm_ctxt_sched_pct_ram.sv
// pct_ram: single-port synchronous RAM, 1-cycle read latency, no reset
//   clk    clock
//   we     write enable
//   addr   shared read/write address
//   wdata  write data
//   rdata  read data, valid the cycle after addr
module pct_ram #(
    parameter int AW = 10,
    parameter int DW = 134
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) r_mem[addr] <= wdata;
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/lstm_ctxt_sched.sv
// lstm_ctxt_sched: per-PID context scheduler between event buffer and LSTM core
//   in_*            event input (valid/ready, payload, type, pid)
//   lstm_valid/ready/mode/data  event issue handshake to the core
//   lstm_load_*     one-cycle context load pulse with ct/ht
//   lstm_ct/ht      live core context, saved on a switch
//   drop_pulse      branch event discarded after the branch limit
module lstm_ctxt_sched
    import lstm_ctxt_pkg::*;
#(
    parameter int PID_BIT  = 10,
    parameter int DATA_W   = 256,
    parameter int CTXT_W   = 64,
    parameter int BR_LIMIT = 30,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_type,
    input  logic [PID_BIT-1:0] in_pid,
    output logic               lstm_valid,
    input  logic               lstm_ready,
    output logic               lstm_mode,
    output logic [DATA_W-1:0]  lstm_data,
    output logic               lstm_load_valid,
    output logic [CTXT_W-1:0]  lstm_ct_load,
    output logic [CTXT_W-1:0]  lstm_ht_load,
    input  logic [CTXT_W-1:0]  lstm_ct,
    input  logic [CTXT_W-1:0]  lstm_ht,
    output logic               drop_pulse
);

    localparam int EW = pct_entry_w(CNT_W, CTXT_W);

    state_t                r_state, w_nxt;
    logic [PID_BIT-1:0]    r_cur_pid, r_pid;
    logic                  r_cur_valid, r_br_done, r_type;
    logic [CNT_W-1:0]      r_br_cnt, w_cnt_inc;
    logic [DATA_W-1:0]     r_data;
    logic [2**PID_BIT-1:0] r_pct_vld;
    logic [EW-1:0]         w_rd, w_ld;
    logic                  w_we, w_hit, w_ld_done;
    logic [PID_BIT-1:0]    w_addr;

    assign w_hit     = r_cur_valid && in_pid == r_cur_pid;
    // Unwritten entries hold stale RAM contents, so they are forced to a zero context.
    assign w_ld      = r_pct_vld[r_pid] ? w_rd : '0;
    assign w_ld_done = w_ld[2*CTXT_W];
    assign w_cnt_inc = r_br_cnt + CNT_W'(1);
    assign lstm_mode = r_type;
    assign lstm_data = r_data;

    pct_ram #(.AW(PID_BIT), .DW(EW)) u_pct (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_addr),
        .wdata ({r_br_cnt, r_br_done, lstm_ct, lstm_ht}),
        .rdata (w_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:       if (in_valid) w_nxt = w_hit ? ((in_type == TYPE_BR && r_br_done) ? S_DROP : S_ISSUE)
                                                      : (r_cur_valid ? S_SAVE : S_LOAD_RD);
            S_SAVE:       if (lstm_ready) w_nxt = S_LOAD_RD;
            S_LOAD_RD:    w_nxt = S_LOAD_APPLY;
            S_LOAD_APPLY: w_nxt = (r_type == TYPE_BR && w_ld_done) ? S_DROP : S_ISSUE;
            S_ISSUE:      if (lstm_ready) w_nxt = S_IDLE;
            S_DROP:       w_nxt = S_IDLE;
            default:      w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready        = r_state == S_IDLE;
        lstm_valid      = r_state == S_ISSUE;
        lstm_load_valid = r_state == S_LOAD_APPLY;
        drop_pulse      = r_state == S_DROP;
        lstm_ct_load    = lstm_load_valid ? w_ld[2*CTXT_W-1:CTXT_W] : '0;
        lstm_ht_load    = lstm_load_valid ? w_ld[CTXT_W-1:0] : '0;
        w_we            = r_state == S_SAVE && lstm_ready;
        // Save targets the resident PID, the load read targets the latched one.
        w_addr          = r_state == S_SAVE ? r_cur_pid : r_pid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_pid   <= '0;
            r_cur_valid <= 1'b0;
            r_br_cnt    <= '0;
            r_br_done   <= 1'b0;
            r_data      <= '0;
            r_type      <= TYPE_SYS;
            r_pid       <= '0;
            r_pct_vld   <= '0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_data <= in_data;
                r_type <= in_type;
                r_pid  <= in_pid;
            end
            if (w_we) r_pct_vld[r_cur_pid] <= 1'b1;
            if (r_state == S_LOAD_APPLY) begin
                r_br_cnt    <= w_ld[EW-1 -: CNT_W];
                r_br_done   <= w_ld_done;
                r_cur_pid   <= r_pid;
                r_cur_valid <= 1'b1;
            end
            // Issued branches always have br_done clear, so the count stops at the limit.
            if (r_state == S_ISSUE && lstm_ready && r_type == TYPE_BR) begin
                r_br_cnt  <= w_cnt_inc;
                r_br_done <= w_cnt_inc == CNT_W'(BR_LIMIT);
            end
        end
    end

endmodule

// File: tb/tb_lstm_ctxt_sched.sv
// tb_lstm_ctxt_sched: directed self-checking bench for lstm_ctxt_sched (BR_LIMIT=3)
module tb_lstm_ctxt_sched;
    localparam int PB = 10, DW = 256, CW = 64;
    localparam logic SYS = 1'b0, BR = 1'b1;

    logic          clk = 1'b0, reset = 1'b1;
    logic          in_valid = 1'b0, in_ready, in_type = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [PB-1:0] in_pid = '0;
    logic          lstm_valid, lstm_ready = 1'b1, lstm_mode, lstm_load_valid, drop_pulse;
    logic [DW-1:0] lstm_data;
    logic [CW-1:0] lstm_ct_load, lstm_ht_load, lstm_ct = '0, lstm_ht = '0;
    int            checks = 0, failures = 0;

    lstm_ctxt_sched #(.PID_BIT(PB), .DATA_W(DW), .CTXT_W(CW), .BR_LIMIT(3), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_type(in_type), .in_pid(in_pid),
        .lstm_valid(lstm_valid), .lstm_ready(lstm_ready), .lstm_mode(lstm_mode), .lstm_data(lstm_data),
        .lstm_load_valid(lstm_load_valid), .lstm_ct_load(lstm_ct_load), .lstm_ht_load(lstm_ht_load),
        .lstm_ct(lstm_ct), .lstm_ht(lstm_ht), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, " rdy"}, in_ready, 1);
        check({tag, " vld"}, lstm_valid, 0);
        check({tag, " ldv"}, lstm_load_valid, 0);
        check({tag, " drp"}, drop_pulse, 0);
    endtask

    task automatic send(input logic t, input logic [PB-1:0] p, input logic [DW-1:0] d);
        check("accept rdy", in_ready, 1);
        in_valid = 1'b1; in_type = t; in_pid = p; in_data = d;
        tick;
        in_valid = 1'b0;
    endtask

    // path: 0 hit, 1 miss with save, 2 miss with nothing resident; lstm_ready assumed high
    task automatic xact(input string tag, input logic t, input logic [PB-1:0] p, input logic [DW-1:0] d,
                        input int path, input logic drop, input logic [CW-1:0] ect, input logic [CW-1:0] eht);
        send(t, p, d);
        if (path == 1) begin
            check({tag, " save ldv"}, lstm_load_valid, 0);
            check({tag, " save vld"}, lstm_valid, 0);
            tick;
        end
        if (path != 0) begin
            check({tag, " rd ldv"}, lstm_load_valid, 0);
            check({tag, " rd rdy"}, in_ready, 0);
            tick;
            check({tag, " ap ldv"}, lstm_load_valid, 1);
            check({tag, " ap vld"}, lstm_valid, 0);
            check({tag, " ap ct"}, lstm_ct_load, ect);
            check({tag, " ap ht"}, lstm_ht_load, eht);
            tick;
        end
        if (drop) begin
            check({tag, " drp"}, drop_pulse, 1);
            check({tag, " drp vld"}, lstm_valid, 0);
        end else begin
            check({tag, " vld"}, lstm_valid, 1);
            check({tag, " ldv"}, lstm_load_valid, 0);
            check({tag, " mode"}, lstm_mode, t);
            check({tag, " data"}, lstm_data, d);
            check({tag, " drp"}, drop_pulse, 0);
        end
        tick;
        idle_chk({tag, " end"});
    endtask

    initial begin
        tick; tick;
        reset = 1'b0;
        idle_chk("reset");
        check("reset mode", lstm_mode, 0);
        check("reset data", lstm_data, 0);
        check("reset ct", lstm_ct_load, 0);
        check("reset ht", lstm_ht_load, 0);

        xact("sys5", SYS, 5, {32{8'hA5}}, 2, 0, 0, 0);

        lstm_ready = 1'b0;
        send(SYS, 5, 256'h3C);
        check("hit vld", lstm_valid, 1);
        check("hit ldv", lstm_load_valid, 0);
        tick;
        check("hit hold vld", lstm_valid, 1);
        check("hit hold data", lstm_data, 256'h3C);
        check("hit hold rdy", in_ready, 0);
        lstm_ready = 1'b1;
        tick;
        idle_chk("hit end");

        lstm_ct = 64'h11; lstm_ht = 64'h22; lstm_ready = 1'b0;
        send(SYS, 9, 256'h99);
        for (int i = 0; i < 4; i++) begin
            check("stall ldv", lstm_load_valid, 0);
            check("stall rdy", in_ready, 0);
            tick;
        end
        lstm_ready = 1'b1;
        tick;
        lstm_ct = 64'h33; lstm_ht = 64'h44;
        check("sw9 rd ldv", lstm_load_valid, 0);
        tick;
        check("sw9 ldv", lstm_load_valid, 1);
        check("sw9 ct", lstm_ct_load, 0);
        check("sw9 ht", lstm_ht_load, 0);
        tick;
        check("sw9 vld", lstm_valid, 1);
        check("sw9 data", lstm_data, 256'h99);
        tick;
        idle_chk("sw9 end");

        xact("back5", SYS, 5, 256'h55, 1, 0, 64'h11, 64'h22);

        lstm_ct = 64'h77; lstm_ht = 64'h78;
        xact("br7a", BR, 7, 256'h71, 1, 0, 0, 0);
        xact("br7b", BR, 7, 256'h72, 0, 0, 0, 0);
        xact("br7c", BR, 7, 256'h73, 0, 0, 0, 0);
        xact("br7d", BR, 7, 256'h74, 0, 1, 0, 0);
        xact("sys7", SYS, 7, 256'h75, 0, 0, 0, 0);

        lstm_ct = 64'h7A; lstm_ht = 64'h7B;
        xact("sys8", SYS, 8, 256'h81, 1, 0, 0, 0);
        lstm_ct = 64'h8A; lstm_ht = 64'h8B;
        xact("br7sat", BR, 7, 256'h76, 1, 1, 64'h7A, 64'h7B);
        xact("sys7b", SYS, 7, 256'h77, 0, 0, 0, 0);
        xact("ret8", SYS, 8, 256'h82, 1, 0, 64'h8A, 64'h8B);
        xact("ret5", BR, 5, 256'h56, 1, 0, 64'h77, 64'h78);

        lstm_ready = 1'b0;
        send(SYS, 9, 256'h9A);
        check("rst save rdy", in_ready, 0);
        reset = 1'b1;
        #1;
        idle_chk("rst async");
        check("rst mode", lstm_mode, 0);
        check("rst data", lstm_data, 0);
        tick;
        idle_chk("rst hold");
        reset = 1'b0;
        lstm_ready = 1'b1;
        xact("post5", SYS, 5, 256'h5A, 2, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
